// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a time-multiplexed active-low 7-segment bus,
// qualifies each digit with a stability filter, decodes it to a hex nibble
// and publishes complete frames atomically.
// Optional feature macro: SEG7_SCAN_DP_EN adds the decimal point input
// seg_dp_n and the committed per-digit output dp_out.
module seg7_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [6:0]              seg_n,
`ifdef SEG7_SCAN_DP_EN
    input  logic                    seg_dp_n,
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic                    frame_valid,
    output logic                    frame_err
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam int unsigned HEX_W = 4 * NUM_DIGITS;
`ifdef SEG7_SCAN_DP_EN
    localparam int unsigned IN_W  = 8 + NUM_DIGITS;
`else
    localparam int unsigned IN_W  = 7 + NUM_DIGITS;
`endif

    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HELD   = 2'd2;

    logic [IN_W-1:0]       in_cur;
    logic [IN_W-1:0]       in_q;
    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic [HEX_W-1:0]      sh_hex_q, sh_hex_d;
    logic [NUM_DIGITS-1:0] sh_err_q, sh_err_d;
    logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d;
    logic [HEX_W-1:0]      hex_q, hex_d;
    logic [NUM_DIGITS-1:0] err_q, err_d;
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic                  fv_q, fv_d;
    logic                  ferr_q, ferr_d;
    logic                  stable_c;
    logic                  capture_c;
    logic [5:0]            dec_c;
`ifdef SEG7_SCAN_DP_EN
    logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0] dp_q, dp_d;

    assign in_cur = {seg_dp_n, seg_n, dig_sel};
    assign dp_out = dp_q;
`else
    assign in_cur = {seg_n, dig_sel};
`endif

    assign hex_out     = hex_q;
    assign digit_err   = err_q;
    assign digit_blank = blank_q;
    assign frame_valid = fv_q;
    assign frame_err   = ferr_q;

    // Segment pattern to {err, blank, nibble}
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'b1000000: r = 6'h00;
            7'b1111001: r = 6'h01;
            7'b0100100: r = 6'h02;
            7'b0110000: r = 6'h03;
            7'b0011001: r = 6'h04;
            7'b0010010: r = 6'h05;
            7'b0000010: r = 6'h06;
            7'b1111000: r = 6'h07;
            7'b0000000: r = 6'h08;
            7'b0011000: r = 6'h09;
            7'b0001000: r = 6'h0A;
            7'b0000011: r = 6'h0B;
            7'b1000110: r = 6'h0C;
            7'b0100001: r = 6'h0D;
            7'b0000110: r = 6'h0E;
            7'b0001110: r = 6'h0F;
            7'b1111111: r = 6'b01_0000;
            default:    r = 6'b10_0000;
        endcase
        return r;
    endfunction

    assign stable_c = (in_cur == in_q) && $onehot(dig_sel);
    assign dec_c    = decode(seg_n);

    // Stability FSM, shadow capture and frame commit
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seen_d     = seen_q;
        sh_hex_d   = sh_hex_q;
        sh_err_d   = sh_err_q;
        sh_blank_d = sh_blank_q;
        hex_d      = hex_q;
        err_d      = err_q;
        blank_d    = blank_q;
        fv_d       = 1'b0;
        ferr_d     = ferr_q;
        capture_c  = 1'b0;
`ifdef SEG7_SCAN_DP_EN
        sh_dp_d    = sh_dp_q;
        dp_d       = dp_q;
`endif

        case (state_q)
            S_WAIT: begin
                cnt_d = '0;
                if (stable_c) begin
                    // Input already seen at two edges; a 2-cycle filter captures now.
                    if (STABLE_CYCLES == 2) begin
                        capture_c = 1'b1;
                        state_d   = S_HELD;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (!stable_c) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 2)) begin
                    capture_c = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HELD: begin
                if (!stable_c) begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
        endcase

        // Commit precedes capture so a same-cycle capture opens the next frame
        if (&seen_q) begin
            hex_d   = sh_hex_q;
            err_d   = sh_err_q;
            blank_d = sh_blank_q;
            fv_d    = 1'b1;
            ferr_d  = |sh_err_q;
            seen_d  = '0;
`ifdef SEG7_SCAN_DP_EN
            dp_d    = sh_dp_q;
`endif
        end

        if (capture_c) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (dig_sel[i]) begin
                    sh_hex_d[4*i +: 4] = dec_c[3:0];
                    sh_blank_d[i]      = dec_c[4];
                    sh_err_d[i]        = dec_c[5];
                    seen_d[i]          = 1'b1;
`ifdef SEG7_SCAN_DP_EN
                    sh_dp_d[i]         = ~seg_dp_n;
`endif
                end
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            in_q       <= '0;
            state_q    <= S_WAIT;
            cnt_q      <= '0;
            seen_q     <= '0;
            sh_hex_q   <= '0;
            sh_err_q   <= '0;
            sh_blank_q <= '0;
            hex_q      <= '0;
            err_q      <= '0;
            blank_q    <= '0;
            fv_q       <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            sh_dp_q    <= '0;
            dp_q       <= '0;
`endif
        end else begin
            in_q       <= in_cur;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            sh_hex_q   <= sh_hex_d;
            sh_err_q   <= sh_err_d;
            sh_blank_q <= sh_blank_d;
            hex_q      <= hex_d;
            err_q      <= err_d;
            blank_q    <= blank_d;
            fv_q       <= fv_d;
            ferr_q     <= ferr_d;
`ifdef SEG7_SCAN_DP_EN
            sh_dp_q    <= sh_dp_d;
            dp_q       <= dp_d;
`endif
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=8).
// Expected frames are queued as stimulus is driven and compared whenever
// the DUT pulses frame_valid.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg_n;
    logic        dp_n_drv;
    logic [3:0]  dig_sel;
    logic [15:0] hex_out;
    logic [3:0]  digit_err;
    logic [3:0]  digit_blank;
    logic        frame_valid;
    logic        frame_err;
    logic [3:0]  dp_out;

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  err;
        logic [3:0]  blank;
        logic        ferr;
        logic [3:0]  dp;
    } frame_t;

    frame_t exp_q[$];
    int     passed   = 0;
    int     total    = 0;
    int     fv_count = 0;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (8)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .seg_n       (seg_n),
`ifdef SEG7_SCAN_DP_EN
        .seg_dp_n    (dp_n_drv),
        .dp_out      (dp_out),
`endif
        .dig_sel     (dig_sel),
        .hex_out     (hex_out),
        .digit_err   (digit_err),
        .digit_blank (digit_blank),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

`ifndef SEG7_SCAN_DP_EN
    assign dp_out = 4'b0000;
`endif

    always #10 clk = ~clk;

    // Scoreboard: every frame_valid pulse must match the oldest queued frame
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            frame_t e;
            fv_count++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_frame: got hex_out=%h err=%b blank=%b, expected no frame",
                         hex_out, digit_err, digit_blank);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (hex_out !== e.hex)
                    $display("FAIL frame_hex: got %h expected %h", hex_out, e.hex);
                else passed++;
                total++;
                if (digit_err !== e.err)
                    $display("FAIL frame_digit_err: got %b expected %b", digit_err, e.err);
                else passed++;
                total++;
                if (digit_blank !== e.blank)
                    $display("FAIL frame_digit_blank: got %b expected %b", digit_blank, e.blank);
                else passed++;
                total++;
                if (frame_err !== e.ferr)
                    $display("FAIL frame_err: got %b expected %b", frame_err, e.ferr);
                else passed++;
`ifdef SEG7_SCAN_DP_EN
                total++;
                if (dp_out !== e.dp)
                    $display("FAIL frame_dp: got %b expected %b", dp_out, e.dp);
                else passed++;
`endif
            end
        end
    end

    task automatic push_frame(input logic [15:0] hex, input logic [3:0] err,
                              input logic [3:0] blank, input logic ferr,
                              input logic [3:0] dp);
        frame_t f;
        f.hex = hex; f.err = err; f.blank = blank; f.ferr = ferr; f.dp = dp;
        exp_q.push_back(f);
    endtask

    // Drive one bus value for n rising edges (called and returns on a negedge)
    task automatic present(input logic [3:0] sel, input logic [6:0] seg, input int n);
        dig_sel = sel;
        seg_n   = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        present(4'b0000, 7'h7F, n);
    endtask

    // Scan the four nibbles of hex, digit 0 first (or digit 3 first when rev)
    task automatic scan4(input logic [15:0] hex, input int hold, input bit rev);
        for (int k = 0; k < 4; k++) begin
            int d;
            logic [3:0] nib;
            d   = rev ? 3 - k : k;
            nib = hex[4*d +: 4];
            present(4'(1 << d), SEG_TAB[nib], hold);
        end
    endtask

    // Bounded wait for all queued frames to be delivered
    task automatic wait_drain(input string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: %0d frames outstanding, expected 0", name, exp_q.size());
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        total++; if (hex_out !== 16'h0) $display("FAIL reset_hex: got %h expected 0000", hex_out); else passed++;
        total++; if (digit_err !== 4'h0) $display("FAIL reset_err: got %b expected 0000", digit_err); else passed++;
        total++; if (digit_blank !== 4'h0) $display("FAIL reset_blank: got %b expected 0000", digit_blank); else passed++;
        total++; if (frame_valid !== 1'b0) $display("FAIL reset_fv: got %b expected 0", frame_valid); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", frame_err); else passed++;
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        int fv0 = fv_count;
        push_frame(16'h0123, 4'h0, 4'h0, 1'b0, 4'h0);
        scan4(16'h0123, 10, 1'b0);
        idle(4);
        wait_drain("basic");
        total++;
        if (fv_count - fv0 != 1) $display("FAIL basic_pulses: got %0d expected 1", fv_count - fv0);
        else passed++;
    endtask

    task automatic test_stability();
        int fv0;
        present(4'b0001, SEG_TAB[5], 7);      // one cycle short: not captured
        present(4'b0010, SEG_TAB[6], 10);
        present(4'b0100, SEG_TAB[7], 10);
        present(4'b1000, SEG_TAB[8], 10);
        fv0 = fv_count;
        idle(6);
        total++;
        if (fv_count != fv0) $display("FAIL short_hold_captured: got %0d frames expected 0", fv_count - fv0);
        else passed++;
        push_frame(16'h8769, 4'h0, 4'h0, 1'b0, 4'h0);
        present(4'b0001, SEG_TAB[9], 8);      // exactly enough: captured
        dig_sel = 4'b0000;
        seg_n   = 7'h7F;
        @(negedge clk);
        total++;
        if (frame_valid !== 1'b1) $display("FAIL commit_latency: frame_valid=%b expected 1", frame_valid);
        else passed++;
        idle(3);
        wait_drain("stability");
    endtask

    task automatic test_multihot();
        int fv0 = fv_count;
        present(4'b0011, SEG_TAB[4], 20);
        idle(4);
        total++;
        if (fv_count != fv0 || digit_err !== 4'h0)
            $display("FAIL multihot: got frames=%0d err=%b expected 0 and 0000", fv_count - fv0, digit_err);
        else passed++;
        push_frame(16'h4321, 4'h0, 4'h0, 1'b0, 4'h0);
        scan4(16'h4321, 9, 1'b0);
        idle(4);
        wait_drain("multihot");
    endtask

    task automatic test_err_blank();
        push_frame(16'hA00A, 4'b0100, 4'b0010, 1'b1, 4'h0);
        present(4'b0001, 7'b0001000, 10);
        present(4'b0010, 7'b1111111, 10);
        present(4'b0100, 7'b1010101, 10);
        present(4'b1000, 7'b0001000, 10);
        idle(4);
        wait_drain("err_blank");
    endtask

    task automatic test_reset_midscan();
        int fv0 = fv_count;
        present(4'b0001, SEG_TAB[1], 10);
        present(4'b0010, SEG_TAB[1], 10);
        present(4'b0100, SEG_TAB[1], 10);
        reset = 1'b1;
        idle(3);
        total++;
        if (hex_out !== 16'h0 || frame_err !== 1'b0 || digit_err !== 4'h0 || digit_blank !== 4'h0)
            $display("FAIL midscan_reset_outputs: got hex=%h ferr=%b err=%b blank=%b expected all 0",
                     hex_out, frame_err, digit_err, digit_blank);
        else passed++;
        reset = 1'b0;
        idle(2);
        push_frame(16'hFEDC, 4'h0, 4'h0, 1'b0, 4'h0);
        scan4(16'hFEDC, 10, 1'b1);            // digit 3 first exposes stale seen bits
        idle(4);
        wait_drain("reset_midscan");
        total++;
        if (fv_count - fv0 != 1) $display("FAIL midscan_pulses: got %0d expected 1", fv_count - fv0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        push_frame(16'h5A5A, 4'h0, 4'h0, 1'b0, 4'h0);
        push_frame(16'h9B07, 4'h0, 4'h0, 1'b0, 4'h0);
        scan4(16'h5A5A, 8, 1'b0);
        scan4(16'h9B07, 8, 1'b0);
        idle(4);
        wait_drain("back_to_back");
    endtask

`ifdef SEG7_SCAN_DP_EN
    task automatic test_dp();
        int fv0;
        push_frame(16'h3210, 4'h0, 4'h0, 1'b0, 4'b0010);
        present(4'b0001, SEG_TAB[0], 10);
        dp_n_drv = 1'b0;
        present(4'b0010, SEG_TAB[1], 10);
        dp_n_drv = 1'b1;
        present(4'b0100, SEG_TAB[2], 10);
        present(4'b1000, SEG_TAB[3], 10);
        idle(4);
        wait_drain("dp");
        // dp toggle restarts the filter: 4 + 7 edges never reaches 8 identical
        present(4'b0001, SEG_TAB[6], 4);
        dp_n_drv = 1'b0;
        present(4'b0001, SEG_TAB[6], 7);
        dp_n_drv = 1'b1;
        present(4'b0010, SEG_TAB[7], 10);
        present(4'b0100, SEG_TAB[8], 10);
        present(4'b1000, SEG_TAB[9], 10);
        fv0 = fv_count;
        idle(6);
        total++;
        if (fv_count != fv0) $display("FAIL dp_toggle_restart: got %0d frames expected 0", fv_count - fv0);
        else passed++;
        push_frame(16'h9871, 4'h0, 4'h0, 1'b0, 4'b0001);
        dp_n_drv = 1'b0;
        present(4'b0001, SEG_TAB[1], 8);
        dp_n_drv = 1'b1;
        idle(4);
        wait_drain("dp_toggle");
    endtask
`endif

    initial begin
        reset    = 1'b1;
        seg_n    = 7'h7F;
        dig_sel  = 4'b0000;
        dp_n_drv = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stability();
        test_multihot();
        test_err_blank();
        test_reset_midscan();
        test_back_to_back();
`ifdef SEG7_SCAN_DP_EN
        test_dp();
`endif
        idle(4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receiving end of the board 7-segment interface: samples a time-multiplexed, active-low segment bus (one digit selected at a time) and decodes each segment pattern back to a 4-bit hex value.
- Digit sampling is qualified by a stability filter; decoded digits are assembled into a frame that updates atomically.
- Used for self-check loopback of display drivers and for reading external 7-segment-scanned instruments.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 8, consecutive identical cycles required before a digit is captured (2..255).

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- seg_n  input  7  segment bus, active-low; bit0=a … bit6=g.
- dig_sel  input  NUM_DIGITS  digit select, active-high; legal only when one-hot.
- hex_out  output  4*NUM_DIGITS  decoded nibbles; digit i at [4i+3:4i].
- digit_err  output  NUM_DIGITS  per-digit: pattern not in decode table and not blank.
- digit_blank  output  NUM_DIGITS  per-digit: pattern was 7'b1111111.
- frame_valid  output  1  one-cycle pulse when hex_out, digit_err and digit_blank are updated.
- frame_err  output  1  OR of digit_err of the committed frame; held until the next commit.

Behaviour:
- Decode table (seg_n g..a → value):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0011000=9, 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F
  - 1111111: nibble 0, blank=1.
  - Any other pattern: nibble 0, err=1.
- Reset: all outputs 0. State=WAIT, counter=0, seen mask=0, shadow registers=0, previous-input registers=0.
- Input registers hold {seg_n, dig_sel} from the previous cycle. "Same" means the current inputs equal the registered ones.
- FSM states:
  - WAIT: counter=0. Go to SETTLE when inputs are same and dig_sel is one-hot.
  - SETTLE: counter increments each same+one-hot cycle.
    - When counter reaches STABLE_CYCLES-2 with inputs still same: capture decode into the shadow slot of the selected digit, set seen[i], go to HELD.
    - Net effect: capture occurs on the STABLE_CYCLES-th consecutive identical cycle.
    - Any change or non-one-hot select: go to WAIT.
  - HELD: no further capture while inputs stay same. Any change or non-one-hot select: go to WAIT.
- dig_sel all-zero or multi-hot is never captured and never flagged as an error.
- Re-capture of an already-seen digit before frame completion overwrites its shadow slot; seen is unchanged.
- Frame commit:
  - In the cycle after seen becomes all ones: copy shadow to outputs, pulse frame_valid, update frame_err, clear seen.
  - Latency from the final qualifying capture edge to frame_valid high is 1 cycle.
- Simultaneous events: a capture on the commit cycle writes the shadow and sets its seen bit after the clear. It belongs to the next frame and is not in the committed data.
- Reset mid-scan discards partial frames. Outputs return to 0 and no frame_valid is issued.
- Counter width is sized for STABLE_CYCLES and must not wrap.

Optional Feature:
- Macro: SEG7_SCAN_DP_EN.
- Defined:
  - Adds input seg_dp_n (1 bit, active-low decimal point), captured alongside seg_n and included in the "same" comparison.
  - Adds output dp_out (NUM_DIGITS, active-high), committed with the frame.
  - Reset value 0.
- Undefined: neither port exists; decode and timing are unchanged.

Test Plan:
- Reset, then present digits 3,2,1,0 as patterns 0110000, 0100100, 1111001, 1000000 on one-hot selects 0001..1000, each held 10 cycles → one frame_valid pulse, hex_out=16'h0123, digit_err=0, digit_blank=0, frame_err=0.
- Hold a digit for exactly STABLE_CYCLES-1=7 cycles, then change it → no capture and seen unchanged. Hold for 8 cycles → captured.
- dig_sel=4'b0011 for 20 cycles with a valid pattern → no capture and no error. Then complete the frame with legal selects → frame_valid with only the legally selected data.
- Digit 2 pattern 1010101, digit 1 pattern 1111111, others 0001000 → hex_out=16'hA00A, digit_err=4'b0100, digit_blank=4'b0010, frame_err=1.
- Assert reset after 3 of 4 digits are captured, then scan a full frame of F,E,d,C → exactly one frame_valid, hex_out=16'hFEDC, with no stale digits.
- With SEG7_SCAN_DP_EN defined: seg_dp_n low on digit 1 only → dp_out=4'b0010. Toggling only seg_dp_n during the stability window restarts the count.
